arithmetic_executor: RTL and testbench

ARITHMETIC_EXECUTOR -- requirements
Module: arithmetic_executor

---
 rtl/arithmetic_executor_if.sv | 35 +++
 rtl/arithmetic_executor.sv | 185 ++++++++++++++++++
 tb/tb_arithmetic_executor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arithmetic_executor_if.sv
// Issue/result bundle for arithmetic_executor: operand selection and
// register-file inputs going in, completion pulse, result bytes and status coming out.
interface arithmetic_executor_if;
    logic       start;
    logic [2:0] alu_sel;
    logic       acc_sel;
    logic [1:0] alu_b_sel;
    logic [3:0] destination_reg_flag;
    logic [7:0] acc_in;
    logic [7:0] b_in;
    logic [7:0] c_in;
    logic [7:0] d_in;
    logic [7:0] imm_in;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [3:0] wr_en;
    logic       carry;
    logic       zero;
    logic       dz_err;
    logic       illegal;

    modport master (
        output start, alu_sel, acc_sel, alu_b_sel, destination_reg_flag,
               acc_in, b_in, c_in, d_in, imm_in,
        input  ready, done, result, result_hi, wr_en, carry, zero, dz_err, illegal
    );

    modport slave (
        input  start, alu_sel, acc_sel, alu_b_sel, destination_reg_flag,
               acc_in, b_in, c_in, d_in, imm_in,
        output ready, done, result, result_hi, wr_en, carry, zero, dz_err, illegal
    );
endinterface

// File: rtl/arithmetic_executor.sv
// 8-bit arithmetic executor: single-cycle ADD/SUB, 8-iteration shift-add MUL
// and restoring DIV, with one-cycle done pulse and register write strobe.
module arithmetic_executor (
    input  logic                  clk,
    input  logic                  rst_n,
    arithmetic_executor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg;
    logic [2:0]  count_reg;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [7:0]  shift_reg;
    logic [15:0] acc_reg;
    logic [3:0]  dest_reg;

    logic [7:0]  result_reg;
    logic [7:0]  result_hi_reg;
    logic [3:0]  wr_en_reg;
    logic        done_reg;
    logic        carry_reg;
    logic        zero_reg;
    logic        dz_err_reg;
    logic        illegal_reg;

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [8:0]  sum_next;
    logic [8:0]  diff_next;
    logic [15:0] mul_acc_next;
    logic [8:0]  rem_shift;
    logic        q_bit;
    logic [8:0]  rem_next;
    logic [7:0]  quo_next;

    always_comb begin
        op_a = bus.acc_sel ? bus.imm_in : bus.acc_in;
        case (bus.alu_b_sel)
            2'b00:   op_b = bus.imm_in;
            2'b01:   op_b = bus.b_in;
            2'b10:   op_b = bus.c_in;
            default: op_b = bus.d_in;
        endcase
        sum_next  = {1'b0, op_a} + {1'b0, op_b};
        // bit 8 of the 9-bit difference is the borrow (A < B)
        diff_next = {1'b0, op_a} - {1'b0, op_b};
    end

    // One iteration step: MUL consumes multiplier bits MSB first; DIV shifts the
    // next dividend bit into the partial remainder and emits one quotient bit.
    always_comb begin
        mul_acc_next = {acc_reg[14:0], 1'b0} + (shift_reg[7] ? {8'h00, a_reg} : 16'h0000);
        rem_shift    = {acc_reg[7:0], shift_reg[7]};
        q_bit        = (rem_shift >= {1'b0, b_reg});
        rem_next     = q_bit ? (rem_shift - {1'b0, b_reg}) : rem_shift;
        quo_next     = {shift_reg[6:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= 3'd0;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            shift_reg     <= 8'h00;
            acc_reg       <= 16'h0000;
            dest_reg      <= 4'h0;
            result_reg    <= 8'h00;
            result_hi_reg <= 8'h00;
            wr_en_reg     <= 4'h0;
            done_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            dz_err_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg  <= 1'b0;
                    wr_en_reg <= 4'h0;
                    if (bus.start) begin
                        dest_reg    <= bus.destination_reg_flag;
                        carry_reg   <= 1'b0;
                        zero_reg    <= 1'b0;
                        dz_err_reg  <= 1'b0;
                        illegal_reg <= 1'b0;
                        case (bus.alu_sel)
                            3'b000: begin
                                result_reg    <= sum_next[7:0];
                                result_hi_reg <= 8'h00;
                                carry_reg     <= sum_next[8];
                                zero_reg      <= (sum_next[7:0] == 8'h00);
                                wr_en_reg     <= bus.destination_reg_flag;
                                done_reg      <= 1'b1;
                                state_reg     <= DONE;
                            end
                            3'b001: begin
                                result_reg    <= diff_next[7:0];
                                result_hi_reg <= 8'h00;
                                carry_reg     <= diff_next[8];
                                zero_reg      <= (diff_next[7:0] == 8'h00);
                                wr_en_reg     <= bus.destination_reg_flag;
                                done_reg      <= 1'b1;
                                state_reg     <= DONE;
                            end
                            3'b010: begin
                                a_reg     <= op_a;
                                shift_reg <= op_b;
                                acc_reg   <= 16'h0000;
                                count_reg <= 3'd7;
                                state_reg <= MUL;
                            end
                            3'b011: begin
                                if (op_b == 8'h00) begin
                                    result_reg    <= 8'hFF;
                                    result_hi_reg <= op_a;
                                    dz_err_reg    <= 1'b1;
                                    done_reg      <= 1'b1;
                                    state_reg     <= DONE;
                                end else begin
                                    b_reg     <= op_b;
                                    shift_reg <= op_a;
                                    acc_reg   <= 16'h0000;
                                    count_reg <= 3'd7;
                                    state_reg <= DIV;
                                end
                            end
                            default: begin
                                result_reg    <= 8'h00;
                                result_hi_reg <= 8'h00;
                                illegal_reg   <= 1'b1;
                                done_reg      <= 1'b1;
                                state_reg     <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_reg   <= mul_acc_next;
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    count_reg <= count_reg - 3'd1;
                    if (count_reg == 3'd0) begin
                        result_reg    <= mul_acc_next[7:0];
                        result_hi_reg <= mul_acc_next[15:8];
                        carry_reg     <= |mul_acc_next[15:8];
                        zero_reg      <= (mul_acc_next[7:0] == 8'h00);
                        wr_en_reg     <= dest_reg;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DIV: begin
                    acc_reg   <= {8'h00, rem_next[7:0]};
                    shift_reg <= quo_next;
                    count_reg <= count_reg - 3'd1;
                    if (count_reg == 3'd0) begin
                        result_reg    <= quo_next;
                        result_hi_reg <= rem_next[7:0];
                        zero_reg      <= (quo_next == 8'h00);
                        wr_en_reg     <= dest_reg;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    wr_en_reg <= 4'h0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready     = (state_reg == IDLE);
    assign bus.done      = done_reg;
    assign bus.result    = result_reg;
    assign bus.result_hi = result_hi_reg;
    assign bus.wr_en     = wr_en_reg;
    assign bus.carry     = carry_reg;
    assign bus.zero      = zero_reg;
    assign bus.dz_err    = dz_err_reg;
    assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_arithmetic_executor.sv
// Directed bench for arithmetic_executor: hand-computed vectors for each
// operation, latency, start-while-busy, divide-by-zero, illegal opcode and reset abort.
module tb_arithmetic_executor;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    arithmetic_executor_if bus ();

    arithmetic_executor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one request for a single cycle; returns at the negedge of the cycle after accept.
    task automatic issue(input logic [2:0] op, input logic asel, input logic [1:0] bsel,
                         input logic [3:0] dest);
        @(negedge clk);
        bus.alu_sel              = op;
        bus.acc_sel              = asel;
        bus.alu_b_sel            = bsel;
        bus.destination_reg_flag = dest;
        bus.start                = 1'b1;
        @(negedge clk);
        bus.start                = 1'b0;
    endtask

    initial begin
        logic done_seen;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.alu_sel = 3'b000;
        bus.acc_sel = 1'b0;
        bus.alu_b_sel = 2'b01;
        bus.destination_reg_flag = 4'b0001;
        bus.acc_in  = 8'h11;
        bus.b_in    = 8'h22;
        bus.c_in    = 8'h00;
        bus.d_in    = 8'h00;
        bus.imm_in  = 8'h00;

        // Start held high during reset must not launch anything
        repeat (3) @(negedge clk);
        chk("rst_hold_done", {15'd0, bus.done}, 16'd0);
        chk("rst_hold_result", {8'd0, bus.result}, 16'h0000);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("rst_ready", {15'd0, bus.ready}, 16'd1);
        chk("rst_outputs", {bus.result, bus.result_hi}, 16'h0000);
        chk("rst_flags", {8'd0, bus.wr_en, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'h0000);
        $display("reset: ready=%0d done=%0d", bus.ready, bus.done);

        // ADD F0+20 = 110
        bus.acc_in = 8'hF0; bus.b_in = 8'h20;
        issue(3'b000, 1'b0, 2'b01, 4'b0001);
        chk("add_done", {15'd0, bus.done}, 16'd1);
        chk("add_result", {bus.result_hi, bus.result}, 16'h0010);
        chk("add_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b1000);
        chk("add_wr_en", {12'd0, bus.wr_en}, 16'h0001);
        chk("add_ready_in_done", {15'd0, bus.ready}, 16'd0);
        $display("ADD F0+20 -> result=%h carry=%0d", bus.result, bus.carry);
        @(negedge clk);
        chk("add_after_done", {14'd0, bus.done, bus.ready}, 16'b01);
        chk("add_after_wr_en", {12'd0, bus.wr_en}, 16'h0000);
        chk("add_flag_hold", {15'd0, bus.carry}, 16'd1);

        // SUB 05-05 = 0
        bus.acc_in = 8'h05; bus.c_in = 8'h05;
        issue(3'b001, 1'b0, 2'b10, 4'b0001);
        chk("sub0_result", {bus.result_hi, bus.result}, 16'h0000);
        chk("sub0_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b0100);
        $display("SUB 05-05 -> result=%h zero=%0d", bus.result, bus.zero);

        // SUB 03-05 = FE with borrow; non-one-hot destination passes through
        @(negedge clk);
        bus.acc_in = 8'h03;
        issue(3'b001, 1'b0, 2'b10, 4'b1011);
        chk("sub_borrow_result", {8'd0, bus.result}, 16'h00FE);
        chk("sub_borrow_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b1000);
        chk("sub_wr_passthru", {12'd0, bus.wr_en}, 16'h000B);
        $display("SUB 03-05 -> result=%h carry=%0d", bus.result, bus.carry);

        // MUL FF*FF = FE01, with mid-op input change and ignored start
        @(negedge clk);
        bus.acc_in = 8'hFF; bus.d_in = 8'hFF;
        issue(3'b010, 1'b0, 2'b11, 4'b0100);
        for (int c = 1; c <= 8; c++) begin
            chk("mul_busy", {14'd0, bus.ready, bus.done}, 16'b00);
            chk("mul_busy_wr_en", {12'd0, bus.wr_en}, 16'h0000);
            if (c == 3) begin
                bus.d_in    = 8'h00;
                bus.acc_in  = 8'h01;
                bus.alu_sel = 3'b000;
                bus.start   = 1'b1;
            end else if (c == 4) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul_done", {14'd0, bus.ready, bus.done}, 16'b01);
        chk("mul_result", {bus.result_hi, bus.result}, 16'hFE01);
        chk("mul_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b1000);
        chk("mul_wr_en", {12'd0, bus.wr_en}, 16'h0004);
        $display("MUL FF*FF -> hi=%h lo=%h", bus.result_hi, bus.result);
        @(negedge clk);
        chk("mul_idle", {14'd0, bus.ready, bus.done}, 16'b10);
        @(negedge clk);
        chk("mul_no_queue", {14'd0, bus.ready, bus.done}, 16'b10);

        // DIV C8/07 = 1C r 04, A from immediate
        bus.imm_in = 8'hC8; bus.b_in = 8'h07;
        issue(3'b011, 1'b1, 2'b01, 4'b0010);
        for (int c = 1; c <= 8; c++) begin
            chk("div_busy_done", {15'd0, bus.done}, 16'd0);
            @(negedge clk);
        end
        chk("div_done", {15'd0, bus.done}, 16'd1);
        chk("div_result", {bus.result_hi, bus.result}, 16'h041C);
        chk("div_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b0000);
        chk("div_wr_en", {12'd0, bus.wr_en}, 16'h0002);
        $display("DIV C8/07 -> q=%h r=%h", bus.result, bus.result_hi);

        // DIV by zero: one-cycle latency, no write
        @(negedge clk);
        bus.b_in = 8'h00;
        issue(3'b011, 1'b1, 2'b01, 4'b0010);
        chk("dz_done", {15'd0, bus.done}, 16'd1);
        chk("dz_result", {bus.result_hi, bus.result}, 16'hC8FF);
        chk("dz_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b0010);
        chk("dz_wr_en", {12'd0, bus.wr_en}, 16'h0000);
        $display("DIV C8/00 -> result=%h dz_err=%0d", bus.result, bus.dz_err);

        // Illegal opcode
        @(negedge clk);
        issue(3'b101, 1'b0, 2'b01, 4'b0001);
        chk("ill_done", {15'd0, bus.done}, 16'd1);
        chk("ill_result", {bus.result_hi, bus.result}, 16'h0000);
        chk("ill_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b0001);
        chk("ill_wr_en", {12'd0, bus.wr_en}, 16'h0000);
        @(negedge clk);
        chk("ill_back_idle", {14'd0, bus.ready, bus.done}, 16'b10);
        $display("ILLEGAL 101 -> illegal=1 expected, back to idle");

        // Reset during MUL iteration 4 aborts with no done
        bus.acc_in = 8'h0F; bus.d_in = 8'h0F;
        issue(3'b010, 1'b0, 2'b11, 4'b0001);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", {14'd0, bus.ready, bus.done}, 16'b10);
        chk("abort_outputs", {bus.result_hi, bus.result}, 16'h0000);
        chk("abort_flags", {8'd0, bus.wr_en, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'h0000);
        done_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done || (bus.wr_en != 4'h0)) done_seen = 1'b1;
        end
        chk("abort_no_done", {15'd0, done_seen}, 16'd0);
        $display("reset mid-MUL -> aborted, ready=%0d", bus.ready);

        // ADD 12+34 after abort
        bus.acc_in = 8'h12; bus.b_in = 8'h34;
        issue(3'b000, 1'b0, 2'b01, 4'b0001);
        chk("post_add_done", {15'd0, bus.done}, 16'd1);
        chk("post_add_result", {bus.result_hi, bus.result}, 16'h0046);
        chk("post_add_flags", {12'd0, bus.carry, bus.zero, bus.dz_err, bus.illegal}, 16'b0000);
        chk("post_add_wr_en", {12'd0, bus.wr_en}, 16'h0001);
        $display("ADD 12+34 -> result=%h", bus.result);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
